// File: rtl/instr_encode_loader.sv
// Packs symbolic instructions into 9-bit machine words and writes them to
// instruction memory at consecutive addresses from a programmed base.
module instr_encode_loader #(
  parameter int unsigned AW    = 8,
  parameter int unsigned LIMIT = 256
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [7:0]    in_field,
  input  logic          finish,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [8:0]    im_data,
  output logic [AW:0]   word_count,
  output logic          full,
  output logic          err,
  output logic          done
);

  localparam int unsigned DW = 9;
  localparam logic [AW:0]   LIMIT_W = (AW+1)'(LIMIT);
  localparam logic [AW-1:0] LAST    = AW'(LIMIT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    r_state;
  logic [AW-1:0] r_wr_ptr;
  logic          r_ready;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_err;
  logic          r_done;

  logic [1:0]    w_state_nxt;
  logic [AW-1:0] w_ptr_nxt;
  logic          w_we_nxt;
  logic [AW-1:0] w_addr_nxt;
  logic [DW-1:0] w_data_nxt;
  logic [AW:0]   w_count_nxt;
  logic          w_full_nxt;
  logic          w_err_nxt;
  logic [DW-1:0] w_enc;
  logic          w_legal;
  logic          w_accept;

  assign w_accept = in_valid & r_ready;

  // Op class to machine-word packing; ops 10-15 are flagged illegal.
  always_comb begin
    w_enc   = '0;
    w_legal = 1'b1;
    case (in_op)
      4'd0:    w_enc = 9'h06F;
      4'd1:    w_enc = {1'b1, in_field};
      4'd2:    w_enc = {2'b01, in_field[6:0]};
      4'd3:    w_enc = {5'b00100, in_field[3:0]};
      4'd4:    w_enc = {5'b00101, in_field[3:0]};
      4'd5:    w_enc = {5'b00111, in_field[3:0]};
      4'd6:    w_enc = 9'h060;
      4'd7:    w_enc = 9'h062;
      4'd8:    w_enc = {5'b00010, in_field[3:0]};
      4'd9:    w_enc = {5'b00011, in_field[3:0]};
      default: w_legal = 1'b0;
    endcase
  end

  // Next-state and next-output logic for the load session.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_wr_ptr;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_count_nxt = r_count;
    w_full_nxt  = r_full;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_ptr_nxt   = base_addr;
          w_count_nxt = '0;
          w_err_nxt   = 1'b0;
          if ({1'b0, base_addr} >= LIMIT_W) begin
            w_full_nxt  = 1'b1;
            w_state_nxt = S_FULL;
          end else begin
            w_full_nxt  = 1'b0;
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          if (w_legal) begin
            w_we_nxt    = 1'b1;
            w_addr_nxt  = r_wr_ptr;
            w_data_nxt  = w_enc;
            w_count_nxt = r_count + (AW+1)'(1);
            // The last legal slot stops the pointer instead of wrapping.
            if (r_wr_ptr == LAST) begin
              w_full_nxt  = 1'b1;
              w_state_nxt = S_FULL;
            end else begin
              w_ptr_nxt = r_wr_ptr + AW'(1);
            end
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        if (finish) w_state_nxt = S_DONE;
      end
      S_FULL: begin
        if (finish) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_ready  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_ptr_nxt;
      r_ready  <= (w_state_nxt == S_LOAD);
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_count  <= w_count_nxt;
      r_full   <= w_full_nxt;
      r_err    <= w_err_nxt;
      r_done   <= (w_state_nxt == S_DONE);
    end
  end

  assign in_ready   = r_ready;
  assign im_we      = r_we;
  assign im_addr    = r_addr;
  assign im_data    = r_data;
  assign word_count = r_count;
  assign full       = r_full;
  assign err        = r_err;
  assign done       = r_done;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: expected writes are queued as
// instructions are offered and retired when the DUT strobes im_we.
module tb_instr_encode_loader;

  localparam int unsigned AW    = 8;
  localparam int unsigned LIMIT = 32;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [7:0]    in_field;
  logic          finish;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [8:0]    im_data;
  logic [AW:0]   word_count;
  logic          full;
  logic          err;
  logic          done;

  instr_encode_loader #(.AW(AW), .LIMIT(LIMIT)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_field(in_field), .finish(finish), .im_we(im_we),
    .im_addr(im_addr), .im_data(im_data), .word_count(word_count),
    .full(full), .err(err), .done(done)
  );

  always #5 Clk = ~Clk;

  int unsigned   n_vec = 0;
  int unsigned   n_mis = 0;
  int unsigned   done_cnt = 0;
  logic [AW-1:0] m_ptr;
  logic [AW-1:0] sb_addr[$];
  logic [8:0]    sb_data[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Retire one expected write per strobe.
  always @(negedge Clk) begin
    if (done) done_cnt++;
    if (im_we) begin
      if (sb_addr.size() == 0) begin
        check("spurious_we", 32'(im_data), 32'h1FF);
      end else begin
        check("im_addr", 32'(im_addr), 32'(sb_addr.pop_front()));
        check("im_data", 32'(im_data), 32'(sb_data.pop_front()));
      end
    end
  end

  // Offer one instruction for a cycle; exp_acc is the bench's expectation of in_ready.
  task automatic send(input logic [3:0] op, input logic [7:0] f, input logic [8:0] exp,
                      input logic exp_acc, input logic fin);
    in_valid = 1'b1;
    in_op    = op;
    in_field = f;
    finish   = fin;
    check("in_ready", 32'(in_ready), 32'(exp_acc));
    if (exp_acc && op <= 4'd9) begin
      sb_addr.push_back(m_ptr);
      sb_data.push_back(exp);
      m_ptr = m_ptr + AW'(1);
    end
    @(negedge Clk);
    in_valid = 1'b0;
    finish   = 1'b0;
  endtask

  task automatic open_session(input logic [AW-1:0] base);
    start     = 1'b1;
    base_addr = base;
    m_ptr     = base;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic close_session();
    finish = 1'b1;
    @(negedge Clk);
    finish = 1'b0;
    check("done_hi", 32'(done), 32'd1);
    @(negedge Clk);
    check("done_lo", 32'(done), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_op = '0; in_field = '0; finish = 1'b0; m_ptr = '0;
    repeat (2) @(negedge Clk);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we",    32'(im_we), 32'd0);
    check("rst_addr",  32'(im_addr), 32'd0);
    check("rst_data",  32'(im_data), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_flags", 32'({full, err, done}), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // Single MOV, then back-to-back ALU/JMP and the fixed-word ops.
    open_session(8'h10);
    send(4'd1, 8'h5A, 9'h15A, 1'b1, 1'b0);
    check("count_1", 32'(word_count), 32'd1);
    send(4'd2, 8'h37, 9'h0B7, 1'b1, 1'b0);
    send(4'd3, 8'h09, 9'h049, 1'b1, 1'b0);
    check("b2b_we", 32'(im_we), 32'd1);
    send(4'd6, 8'hFF, 9'h060, 1'b1, 1'b0);
    send(4'd7, 8'hFF, 9'h062, 1'b1, 1'b0);
    send(4'd0, 8'hA5, 9'h06F, 1'b1, 1'b0);
    check("count_6", 32'(word_count), 32'd6);

    // Illegal op between two IMMs is dropped and sets err.
    send(4'd5, 8'hF3, 9'h073, 1'b1, 1'b0);
    send(4'hF, 8'h00, 9'h000, 1'b1, 1'b0);
    check("illegal_no_we", 32'(im_we), 32'd0);
    check("err_set", 32'(err), 32'd1);
    send(4'd5, 8'h03, 9'h073, 1'b1, 1'b0);
    check("count_8", 32'(word_count), 32'd8);
    close_session();
    check("err_hold", 32'(err), 32'd1);

    // Run into the address limit.
    open_session(8'h1E);
    check("err_clear", 32'(err), 32'd0);
    check("count_clear", 32'(word_count), 32'd0);
    send(4'd5, 8'h01, 9'h071, 1'b1, 1'b0);
    check("not_full", 32'(full), 32'd0);
    send(4'd5, 8'h02, 9'h072, 1'b1, 1'b0);
    check("full_set", 32'(full), 32'd1);
    send(4'd5, 8'h03, 9'h073, 1'b0, 1'b0);
    check("full_count", 32'(word_count), 32'd2);
    close_session();
    check("full_hold", 32'(full), 32'd1);

    // Base beyond the limit goes straight to FULL.
    open_session(8'h40);
    check("oob_full", 32'(full), 32'd1);
    check("oob_ready", 32'(in_ready), 32'd0);
    check("oob_count", 32'(word_count), 32'd0);
    close_session();

    // finish in the same cycle as a STORE still writes it.
    done_cnt = 0;
    open_session(8'h05);
    send(4'd9, 8'h05, 9'h035, 1'b1, 1'b1);
    check("fin_done", 32'(done), 32'd1);
    check("fin_count", 32'(word_count), 32'd1);
    @(negedge Clk);
    check("fin_pulses", done_cnt, 32'd1);
    check("fin_idle", 32'(in_ready), 32'd0);

    // Reset while an accept is offered cancels the write.
    open_session(8'h00);
    Reset = 1'b1; in_valid = 1'b1; in_op = 4'd1; in_field = 8'h01;
    @(negedge Clk);
    in_valid = 1'b0;
    check("mid_rst_we", 32'(im_we), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_count", 32'(word_count), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    open_session(8'h08);
    start = 1'b1; base_addr = 8'h00;
    @(negedge Clk);
    start = 1'b0;
    send(4'd5, 8'h01, 9'h071, 1'b1, 1'b0);
    check("restart_count", 32'(word_count), 32'd1);
    close_session();

    check("sb_drained", 32'(sb_addr.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
